// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: CPU opcodes, loader states and default widths.
package program_loader_pkg;

  localparam int DEF_AW = 5;
  localparam int DEF_DW = 8;
  localparam int DEF_DEPTH = 1 << DEF_AW;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Opcode sits in the top three bits of every instruction.
  function automatic logic is_halt(input logic [DEF_DW-1:0] instr);
    return instr[DEF_DW-1 -: 3] == OP_HLT;
  endfunction

endpackage

// File: rtl/program_loader_prog_ram.sv
// prog_ram: DEPTH x DW program store with sync write, async read and single-cycle bulk clear.
module prog_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: this array is reset and bulk-cleared, so it maps to flops rather than an SRAM macro;
  // that is intended, since unwritten slots must read back as HLT after every load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// program_loader: streams a host program into prog_ram, holds the CPU in load, then serves ram[cpu_pc].
// Optional feature: define PROG_CHECKSUM_EN to treat the host_last byte as a checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [DW-1:0] host_data,
  input  logic          host_last,
  input  logic [AW-1:0] cpu_pc,
  output logic [DW-1:0] cpu_instr,
  output logic          cpu_load,
  output logic          running,
  output logic          halted,
  output logic          trunc,
  output logic          err,
  output logic [AW:0]   load_count
);

  state_e        state;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_q;
  logic          trunc_q;
  logic [DW-1:0] ram_rdata;
  logic          accept;
  logic          store;
  logic          last_slot;

  assign host_ready = (state == ST_LOAD);
  assign running    = (state == ST_RUN);
  assign cpu_load   = ~running;
  // A simultaneous start wins over the byte, so the byte is neither stored nor counted.
  assign accept     = host_valid & host_ready & ~start;
  assign last_slot  = (wr_ptr == AW'(DEPTH - 1));

`ifdef PROG_CHECKSUM_EN
  logic [DW-1:0] sum_q;
  logic [DW-1:0] sum_chk;
  logic          err_q;

  assign sum_chk = sum_q + host_data;
  assign store   = accept & ~host_last;
  assign err     = err_q;
`else
  assign store   = accept;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      wr_ptr  <= '0;
      count_q <= '0;
      trunc_q <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else if (start) begin
      // NOTE: non-blocking assignments keep every register here sampling pre-edge values,
      // so ordering inside this block never changes behaviour.
      state   <= ST_LOAD;
      wr_ptr  <= '0;
      count_q <= '0;
      trunc_q <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else if (accept) begin
`ifdef PROG_CHECKSUM_EN
      if (host_last) begin
        state <= (sum_chk == '0) ? ST_RUN : ST_ERR;
        err_q <= (sum_chk != '0);
      end else begin
        wr_ptr  <= wr_ptr + 1'b1;
        count_q <= count_q + 1'b1;
        sum_q   <= sum_chk;
        if (last_slot) begin
          state   <= ST_RUN;
          trunc_q <= 1'b1;
        end
      end
`else
      wr_ptr  <= wr_ptr + 1'b1;
      count_q <= count_q + 1'b1;
      if (host_last || last_slot) state <= ST_RUN;
      if (!host_last && last_slot) trunc_q <= 1'b1;
`endif
    end
  end

  prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_prog_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (start),
    .we      (store),
    .waddr   (wr_ptr),
    .wdata   (host_data),
    .raddr   (cpu_pc),
    .rdata   (ram_rdata)
  );

  // Zero-latency path into the CPU data_in; outside RUN the CPU sees HLT.
  assign cpu_instr  = running ? ram_rdata : '0;
  assign halted     = running & is_halt(ram_rdata);
  assign trunc      = trunc_q;
  assign load_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized loads against a queue model.
module tb_program_loader;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       host_valid;
  logic       host_ready;
  logic [7:0] host_data;
  logic       host_last;
  logic [4:0] cpu_pc;
  logic [7:0] cpu_instr;
  logic       cpu_load;
  logic       running;
  logic       halted;
  logic       trunc;
  logic       err;
  logic [5:0] load_count;

  int vectors = 0;
  int fails   = 0;

  // Reference model: the program is simply the queue of bytes stored so far.
  logic [7:0] prog[$];
  bit         m_load, m_run, m_err, m_trunc;
  logic [7:0] m_sum;

  program_loader dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_data  (host_data),
    .host_last  (host_last),
    .cpu_pc     (cpu_pc),
    .cpu_instr  (cpu_instr),
    .cpu_load   (cpu_load),
    .running    (running),
    .halted     (halted),
    .trunc      (trunc),
    .err        (err),
    .load_count (load_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] exp_instr(input int pc);
    if (!m_run) return 8'h00;
    if (pc < prog.size()) return prog[pc];
    return 8'h00;
  endfunction

  task automatic model_reset();
    prog.delete();
    m_load = 0; m_run = 0; m_err = 0; m_trunc = 0; m_sum = 8'h00;
  endtask

  task automatic model_edge(input logic s, input logic v, input logic [7:0] d, input logic l);
    if (s) begin
      prog.delete();
      m_load = 1; m_run = 0; m_err = 0; m_trunc = 0; m_sum = 8'h00;
    end else if (m_load && v) begin
`ifdef PROG_CHECKSUM_EN
      if (l) begin
        m_load = 0;
        if (((int'(m_sum) + int'(d)) % 256) == 0) m_run = 1;
        else m_err = 1;
      end else begin
        prog.push_back(d);
        m_sum = m_sum + d;
        if (prog.size() == 32) begin
          m_load = 0; m_run = 1; m_trunc = 1;
        end
      end
`else
      prog.push_back(d);
      if (l || prog.size() == 32) begin
        m_load = 0; m_run = 1;
        m_trunc = !l && prog.size() == 32;
      end
`endif
    end
  endtask

  task automatic check_all(input string ctx);
    logic [7:0] e;
    e = exp_instr(int'(cpu_pc));
    check({ctx, ".host_ready"}, 32'(host_ready), 32'(m_load));
    check({ctx, ".cpu_load"},   32'(cpu_load),   32'(!m_run));
    check({ctx, ".running"},    32'(running),    32'(m_run));
    check({ctx, ".trunc"},      32'(trunc),      32'(m_trunc));
    check({ctx, ".err"},        32'(err),        32'(m_err));
    check({ctx, ".load_count"}, 32'(load_count), 32'(prog.size()));
    check({ctx, ".cpu_instr"},  32'(cpu_instr),  32'(e));
    check({ctx, ".halted"},     32'(halted),     32'(m_run && e[7:5] == 3'b000));
  endtask

  // One clock: inputs applied at the negedge, model stepped at the posedge, outputs checked #1 later.
  task automatic cyc(input string ctx, input logic s, input logic v, input logic [7:0] d, input logic l);
    start = s; host_valid = v; host_data = d; host_last = l;
    cpu_pc = 5'($urandom_range(0, 31));
    @(posedge clock);
    model_edge(s, v, d, l);
    #1 check_all(ctx);
    @(negedge clock);
  endtask

  // Reads every RAM slot through cpu_pc; inputs are idle so state cannot move meanwhile.
  task automatic sweep(input string ctx);
    logic [7:0] e;
    start = 0; host_valid = 0; host_last = 0;
    for (int pc = 0; pc < 32; pc++) begin
      cpu_pc = 5'(pc);
      #1;
      e = exp_instr(pc);
      check({ctx, ".sweep_instr"}, 32'(cpu_instr), 32'(e));
      check({ctx, ".sweep_halted"}, 32'(halted), 32'(m_run && e[7:5] == 3'b000));
    end
    @(negedge clock);
  endtask

  initial begin
    int n, sent;
    bit s, v, l;
    reset_n = 0; start = 0; host_valid = 0; host_data = 0; host_last = 0; cpu_pc = 0;
    model_reset();
    #1 check_all("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;
    cyc("idle", 0, 1, 8'h77, 1);

    // Scenario 1: three-byte program ending in HLT.
    cyc("t1_start", 1, 0, 8'h00, 0);
    cyc("t1_b0", 0, 1, 8'hA5, 0);
    cyc("t1_b1", 0, 1, 8'h43, 0);
    cyc("t1_b2", 0, 1, 8'h00, 1);
`ifndef PROG_CHECKSUM_EN
    check("t1_cpu_load_fell", 32'(cpu_load), 32'd0);
    check("t1_load_count", 32'(load_count), 32'd3);
`endif
    sweep("t1");

    // Scenario 2: a valid gap must not store anything.
    cyc("t2_start", 1, 0, 8'h00, 0);
    cyc("t2_b0", 0, 1, 8'h11, 0);
    cyc("t2_gap", 0, 0, 8'h99, 0);
    cyc("t2_b1", 0, 1, 8'h22, 0);
    check("t2_load_count", 32'(load_count), 32'd2);
    cyc("t2_last", 0, 1, 8'h33, 1);
    sweep("t2");

    // Scenario 3: DEPTH bytes without host_last truncate; the extra byte is dropped.
    cyc("t3_start", 1, 0, 8'h00, 0);
    for (int i = 0; i < 32; i++) cyc("t3_byte", 0, 1, 8'($urandom), 0);
    check("t3_trunc", 32'(trunc), 32'd1);
    cyc("t3_extra", 0, 1, 8'hFF, 0);
    cyc("t3_extra_last", 0, 1, 8'hFE, 1);
    sweep("t3");

    // Scenario 4: restart from RUN with a one-byte program.
    cyc("t4_start", 1, 0, 8'h00, 0);
    cyc("t4_b0", 0, 1, 8'hE0, 1);
    sweep("t4");

    // Scenario 5: async reset in the middle of a load.
    cyc("t5_start", 1, 0, 8'h00, 0);
    cyc("t5_b0", 0, 1, 8'h5A, 0);
    cyc("t5_b1", 0, 1, 8'h6B, 0);
    #2 reset_n = 0;
    model_reset();
    #1 check_all("t5_reset");
    @(negedge clock);
    reset_n = 1;
    cyc("t5_after", 0, 1, 8'h12, 1);
    sweep("t5");

`ifdef PROG_CHECKSUM_EN
    // Scenario 6: good and bad checksum.
    cyc("t6_start", 1, 0, 8'h00, 0);
    cyc("t6_b0", 0, 1, 8'h10, 0);
    cyc("t6_b1", 0, 1, 8'h20, 0);
    cyc("t6_ck", 0, 1, 8'hD0, 1);
    check("t6_good_running", 32'(running), 32'd1);
    cyc("t6b_start", 1, 0, 8'h00, 0);
    cyc("t6b_b0", 0, 1, 8'h10, 0);
    cyc("t6b_b1", 0, 1, 8'h20, 0);
    cyc("t6b_ck", 0, 1, 8'hD1, 1);
    check("t6_bad_err", 32'(err), 32'd1);
    check("t6_bad_cpu_load", 32'(cpu_load), 32'd1);
    sweep("t6");
`endif

    // Randomized loads: random lengths (some truncating), valid gaps and occasional restarts.
    for (int it = 0; it < 25; it++) begin
      cyc("rnd_start", 1, 0, 8'h00, 0);
      n = $urandom_range(1, 34);
      sent = 0;
      for (int k = 0; k < 200 && m_load; k++) begin
        s = ($urandom_range(0, 60) == 0);
        v = ($urandom_range(0, 3) != 0);
        l = (sent >= n - 1);
        cyc("rnd_byte", s, v, 8'($urandom), l);
        if (s) sent = 0;
        else if (v) sent++;
      end
      for (int k = 0; k < 3; k++) cyc("rnd_idle", 0, 1'($urandom), 8'($urandom), 1'($urandom));
      sweep("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
